// File: rtl/display_scan_if.sv
// Bundles the update strobe/data going into the scan controller and the
// decoder/digit-select signals coming out of it.
interface display_scan_if;
  logic        LOAD;
  logic [11:0] CODES;
  logic [3:0]  EN_MASK;
  logic        DEC_A;
  logic        DEC_B;
  logic        DEC_C;
  logic [3:0]  DIG_N;
  logic        LOAD_ACK;
  logic        FRAME;

  modport master (
    output LOAD, CODES, EN_MASK,
    input  DEC_A, DEC_B, DEC_C, DIG_N, LOAD_ACK, FRAME
  );

  modport slave (
    input  LOAD, CODES, EN_MASK,
    output DEC_A, DEC_B, DEC_C, DIG_N, LOAD_ACK, FRAME
  );
endinterface

// File: rtl/display_scan_controller.sv
// Round-robin scan of four digits through one shared 3-bit decoder, with a
// blanking gap before each digit and frame-synchronous code/mask updates.
module display_scan_controller #(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic          CLK,
  input  logic          RST,
  display_scan_if.slave bus
);

  localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(PRESCALE - 1);

  typedef enum logic {ST_BLANK, ST_DRIVE} state_e;

  state_e           state_q;
  logic [1:0]       idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [11:0]      codes_q;
  logic [3:0]       mask_q;
  logic [11:0]      pend_codes_q;
  logic [3:0]       pend_mask_q;
  logic             pend_vld_q;
  logic [3:0]       dig_n_q;
  logic [2:0]       dec_q;
  logic             ack_q;
  logic             frame_q;

  logic [1:0]  idx_d;
  logic        apply;
  logic        upd;
  logic [11:0] codes_d;
  logic [3:0]  mask_d;
  logic [3:0]  drive_dig_n;

  function automatic logic [2:0] code_of(input logic [11:0] codes, input logic [1:0] idx);
    case (idx)
      2'd0:    code_of = codes[2:0];
      2'd1:    code_of = codes[5:3];
      2'd2:    code_of = codes[8:6];
      default: code_of = codes[11:9];
    endcase
  endfunction

  // The apply edge is the last DRIVE cycle of digit 3; a LOAD on that very
  // cycle bypasses the pending registers.
  always_comb begin
    idx_d       = idx_q + 2'd1;
    apply       = (state_q == ST_DRIVE) && (cnt_q == DRIVE_LAST) && (idx_q == 2'd3);
    upd         = bus.LOAD || pend_vld_q;
    codes_d     = codes_q;
    mask_d      = mask_q;
    if (apply && upd) begin
      codes_d = bus.LOAD ? bus.CODES   : pend_codes_q;
      mask_d  = bus.LOAD ? bus.EN_MASK : pend_mask_q;
    end
    drive_dig_n = ~({3'b000, mask_q[idx_q]} << idx_q);
  end

  always_ff @(posedge CLK) begin
    if (bus.LOAD) begin
      pend_codes_q <= bus.CODES;
      pend_mask_q  <= bus.EN_MASK;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_BLANK;
      idx_q      <= 2'd0;
      cnt_q      <= '0;
      codes_q    <= '0;
      mask_q     <= '0;
      pend_vld_q <= 1'b0;
      dig_n_q    <= 4'b1111;
      dec_q      <= 3'b000;
      ack_q      <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      ack_q   <= 1'b0;
      frame_q <= 1'b0;
      if (bus.LOAD && !apply) pend_vld_q <= 1'b1;
      case (state_q)
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_q <= ST_DRIVE;
            cnt_q   <= '0;
            dig_n_q <= drive_dig_n;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          if (cnt_q == DRIVE_LAST) begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            idx_q   <= idx_d;
            dig_n_q <= 4'b1111;
            dec_q   <= code_of(codes_d, idx_d);
            codes_q <= codes_d;
            mask_q  <= mask_d;
            if (apply) begin
              frame_q <= 1'b1;
              if (upd) begin
                pend_vld_q <= 1'b0;
                ack_q      <= 1'b1;
              end
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.DEC_A    = dec_q[2];
  assign bus.DEC_B    = dec_q[1];
  assign bus.DEC_C    = dec_q[0];
  assign bus.DIG_N    = dig_n_q;
  assign bus.LOAD_ACK = ack_q;
  assign bus.FRAME    = frame_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: directed scenarios plus random loads and
// resets, compared every cycle against a frame-position reference model.
module tb_display_scan_controller;

  localparam int P     = 8;
  localparam int B     = 2;
  localparam int SLOT  = P + B;
  localparam int FRAME = 4 * SLOT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  display_scan_if bus ();

  display_scan_controller #(.PRESCALE(P), .BLANK_CYCLES(B)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference state: edges since reset and the frame-level register view.
  int          n         = 0;
  logic [11:0] m_codes   = '0;
  logic [3:0]  m_mask    = '0;
  logic [11:0] m_pcodes  = '0;
  logic [3:0]  m_pmask   = '0;
  bit          m_pend    = 1'b0;
  int          ack_count = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n);
    end
  endtask

  task automatic step(input logic r, input logic ld, input logic [11:0] c, input logic [3:0] m);
    int p, slot, w;
    logic [3:0]  e_dig;
    logic [2:0]  e_dec;
    logic [11:0] tmp;
    bit          e_ack, e_frame;
    @(negedge clk);
    rst         = r;
    bus.LOAD    = ld;
    bus.CODES   = c;
    bus.EN_MASK = m;
    @(posedge clk);
    e_ack   = 1'b0;
    e_frame = 1'b0;
    if (r) begin
      n = 0; m_codes = '0; m_mask = '0; m_pend = 1'b0;
    end else begin
      n++;
      if (n % FRAME == 0) begin
        e_frame = 1'b1;
        if (ld) begin
          m_codes = c; m_mask = m; m_pend = 1'b0; e_ack = 1'b1;
        end else if (m_pend) begin
          m_codes = m_pcodes; m_mask = m_pmask; m_pend = 1'b0; e_ack = 1'b1;
        end
      end else if (ld) begin
        m_pcodes = c; m_pmask = m; m_pend = 1'b1;
      end
    end
    p    = n % FRAME;
    slot = p / SLOT;
    w    = p % SLOT;
    e_dig = 4'b1111;
    if (!r && w >= B && m_mask[slot]) e_dig[slot] = 1'b0;
    tmp   = m_codes >> (3 * slot);
    e_dec = r ? 3'b000 : tmp[2:0];
    #1;
    check("dig_n", 32'(bus.DIG_N), 32'(e_dig));
    check("dec", 32'({bus.DEC_A, bus.DEC_B, bus.DEC_C}), 32'(e_dec));
    check("load_ack", 32'(bus.LOAD_ACK), 32'(e_ack));
    check("frame", 32'(bus.FRAME), 32'(e_frame));
    if (bus.LOAD_ACK === 1'b1) ack_count++;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 12'h000, 4'h0);
  endtask

  task automatic do_reset(input int k);
    for (int i = 0; i < k; i++) step(1'b1, 1'b0, 12'h000, 4'h0);
  endtask

  task automatic load(input logic [11:0] c, input logic [3:0] m);
    step(1'b0, 1'b1, c, m);
  endtask

  initial begin
    bus.LOAD    = 1'b0;
    bus.CODES   = '0;
    bus.EN_MASK = '0;

    // Reset, then one plain frame of blank scanning.
    do_reset(3);
    idle(FRAME);

    // Single load mid-frame, shown from the next wrap onward.
    do_reset(1);
    idle(4);
    load(12'o7531, 4'b1111);
    idle(2 * FRAME);

    // Two loads in one frame: latest wins, exactly one acknowledge.
    do_reset(1);
    idle(9);
    load(12'o1111, 4'b1111);
    idle(9);
    ack_count = 0;
    load(12'o2222, 4'b1111);
    idle(FRAME - 20 + 5);
    check("single_ack", 32'(ack_count), 32'd1);

    // Partial enable mask over a full frame.
    load(12'o4567, 4'b0101);
    idle(2 * FRAME);

    // Load landing exactly on the wrap cycle.
    while ((n + 1) % FRAME != 0) idle(1);
    load(12'o3210, 4'b1011);
    ack_count = 0;
    idle(FRAME);
    check("no_leftover_ack", 32'(ack_count), 32'd0);

    // Reset during the digit-2 drive slot with an update pending.
    load(12'o0000, 4'b1111);
    idle(2 * SLOT + B + 2 - 1);
    ack_count = 0;
    step(1'b1, 1'b0, 12'h000, 4'h0);
    idle(2 * FRAME);
    check("discarded_ack", 32'(ack_count), 32'd0);

    // Random loads and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0)
        step(1'b1, 1'b0, 12'h000, 4'h0);
      else if ($urandom_range(0, 15) == 0)
        load(12'($urandom), 4'($urandom));
      else
        idle(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
